// File: rtl/riscv_pipeline_top.sv
// Five-stage RV32I subset pipeline (add/sub/and/or/addi/lw/sw/beq) with internal ROM,
// forwarding, load-use stall and EX-resolved beq; RF and DM are probeable instances.

module riscv_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] RF [0:31];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) RF[i] <= '0;
    end else if (we && wa != 5'd0) begin
      RF[wa] <= wd;
    end
  end

  // Write-through so an instruction in ID sees the value WB commits this cycle
  assign rd1 = (ra1 == 5'd0) ? '0 : ((we && wa == ra1) ? wd : RF[ra1]);
  assign rd2 = (ra2 == 5'd0) ? '0 : ((we && wa == ra2) ? wd : RF[ra2]);
endmodule

module riscv_datamem (
  input  logic        clock,
  input  logic        we,
  input  logic [5:0]  widx,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [7:0] data [0:255] = '{0: 8'h6D, 40: 8'hFF, 42: 8'hFF, default: 8'h00};

  always_ff @(posedge clock) begin
    if (we) begin
      data[{widx, 2'd0}] <= wdata[7:0];
      data[{widx, 2'd1}] <= wdata[15:8];
      data[{widx, 2'd2}] <= wdata[23:16];
      data[{widx, 2'd3}] <= wdata[31:24];
    end
  end

  assign rdata = {data[{widx, 2'd3}], data[{widx, 2'd2}], data[{widx, 2'd1}], data[{widx, 2'd0}]};
endmodule

module riscv_pipeline_top (
  input logic clock,
  input logic reset
);
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR} alu_op_t;

  typedef struct packed {
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    logic    memtoreg;
    logic    alusrc;
    logic    branch;
    alu_op_t alu;
  } ctrl_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [31:0] pc, instr_f;
  logic [31:0] ifid_pc, ifid_instr;

  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [6:0]  id_op, id_f7;
  logic [2:0]  id_f3;
  logic [31:0] id_imm, rf_rd1, rf_rd2;
  ctrl_t       id_ctrl;

  logic [31:0] idex_pc, idex_a, idex_b, idex_imm;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  ctrl_t       idex_ctrl;

  logic [31:0] ex_a, ex_b, ex_opb, ex_result, ex_target;
  logic        ex_taken, ld_stall;

  logic        exmem_regwrite, exmem_memwrite, exmem_memtoreg;
  logic [31:0] exmem_alu, exmem_wdata;
  logic [4:0]  exmem_rd;
  logic [31:0] mem_rdata;

  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;

  always_comb begin
    case (pc[9:2])
      8'd0:    instr_f = 32'h00002103;
      8'd1:    instr_f = 32'h01100193;
      8'd2:    instr_f = 32'h00318213;
      8'd3:    instr_f = 32'h00F18293;
      8'd4:    instr_f = 32'h00518333;
      8'd5:    instr_f = 32'h005203B3;
      8'd6:    instr_f = 32'h02802403;
      8'd7:    instr_f = 32'h10040493;
      8'd8:    instr_f = 32'h00000013;
      8'd9:    instr_f = 32'h06902223;
      8'd10:   instr_f = 32'h03200513;
      default: instr_f = 32'h00000013;
    endcase
  end

  assign id_op  = ifid_instr[6:0];
  assign id_rd  = ifid_instr[11:7];
  assign id_f3  = ifid_instr[14:12];
  assign id_rs1 = ifid_instr[19:15];
  assign id_rs2 = ifid_instr[24:20];
  assign id_f7  = ifid_instr[31:25];

  always_comb begin
    id_ctrl = '0;
    case (id_op)
      OP_R: begin
        if (id_f7 == 7'b0000000 || (id_f7 == 7'b0100000 && id_f3 == 3'b000)) begin
          case (id_f3)
            3'b000: begin
              id_ctrl.regwrite = 1'b1;
              id_ctrl.alu      = id_f7[5] ? ALU_SUB : ALU_ADD;
            end
            3'b111: begin
              id_ctrl.regwrite = 1'b1;
              id_ctrl.alu      = ALU_AND;
            end
            3'b110: begin
              id_ctrl.regwrite = 1'b1;
              id_ctrl.alu      = ALU_OR;
            end
            default: id_ctrl = '0;
          endcase
        end
      end
      OP_IMM: begin
        if (id_f3 == 3'b000) begin
          id_ctrl.regwrite = 1'b1;
          id_ctrl.alusrc   = 1'b1;
        end
      end
      OP_LOAD: begin
        if (id_f3 == 3'b010) begin
          id_ctrl.regwrite = 1'b1;
          id_ctrl.memread  = 1'b1;
          id_ctrl.memtoreg = 1'b1;
          id_ctrl.alusrc   = 1'b1;
        end
      end
      OP_STORE: begin
        if (id_f3 == 3'b010) begin
          id_ctrl.memwrite = 1'b1;
          id_ctrl.alusrc   = 1'b1;
        end
      end
      OP_BRANCH: begin
        if (id_f3 == 3'b000) id_ctrl.branch = 1'b1;
      end
      default: id_ctrl = '0;
    endcase
  end

  always_comb begin
    case (id_op)
      OP_STORE:  id_imm = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
      OP_BRANCH: id_imm = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                           ifid_instr[30:25], ifid_instr[11:8], 1'b0};
      default:   id_imm = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
    endcase
  end

  riscv_regfile RF (
    .clock (clock),
    .reset (reset),
    .ra1   (id_rs1),
    .ra2   (id_rs2),
    .we    (memwb_regwrite),
    .wa    (memwb_rd),
    .wd    (memwb_data),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

  assign ld_stall = idex_ctrl.memread && idex_rd != 5'd0 &&
                    (idex_rd == id_rs1 || idex_rd == id_rs2);

  always_comb begin
    ex_a = idex_a;
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == idex_rs1)      ex_a = exmem_alu;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == idex_rs1) ex_a = memwb_data;
    ex_b = idex_b;
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == idex_rs2)      ex_b = exmem_alu;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == idex_rs2) ex_b = memwb_data;
    ex_opb = idex_ctrl.alusrc ? idex_imm : ex_b;
    ex_result = '0;
    case (idex_ctrl.alu)
      ALU_ADD: ex_result = ex_a + ex_opb;
      ALU_SUB: ex_result = ex_a - ex_opb;
      ALU_AND: ex_result = ex_a & ex_opb;
      ALU_OR:  ex_result = ex_a | ex_opb;
      default: ex_result = '0;
    endcase
    ex_taken  = idex_ctrl.branch && (ex_a == ex_b);
    ex_target = idex_pc + idex_imm;
  end

  // A taken branch outranks the load-use stall: the stalled instruction is flushed anyway
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= '0;
      ifid_pc    <= '0;
      ifid_instr <= '0;
    end else if (ex_taken) begin
      pc         <= ex_target;
      ifid_pc    <= '0;
      ifid_instr <= '0;
    end else if (!ld_stall) begin
      pc         <= pc + 32'd4;
      ifid_pc    <= pc;
      ifid_instr <= instr_f;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idex_pc   <= '0;
      idex_a    <= '0;
      idex_b    <= '0;
      idex_imm  <= '0;
      idex_rs1  <= '0;
      idex_rs2  <= '0;
      idex_rd   <= '0;
      idex_ctrl <= '0;
    end else if (ex_taken || ld_stall) begin
      idex_pc   <= '0;
      idex_a    <= '0;
      idex_b    <= '0;
      idex_imm  <= '0;
      idex_rs1  <= '0;
      idex_rs2  <= '0;
      idex_rd   <= '0;
      idex_ctrl <= '0;
    end else begin
      idex_pc   <= ifid_pc;
      idex_a    <= rf_rd1;
      idex_b    <= rf_rd2;
      idex_imm  <= id_imm;
      idex_rs1  <= id_rs1;
      idex_rs2  <= id_rs2;
      idex_rd   <= id_rd;
      idex_ctrl <= id_ctrl;
    end
  end

  riscv_datamem DM (
    .clock (clock),
    .we    (exmem_memwrite),
    .widx  (exmem_alu[7:2]),
    .wdata (exmem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exmem_regwrite <= 1'b0;
      exmem_memwrite <= 1'b0;
      exmem_memtoreg <= 1'b0;
      exmem_alu      <= '0;
      exmem_wdata    <= '0;
      exmem_rd       <= '0;
      memwb_regwrite <= 1'b0;
      memwb_rd       <= '0;
      memwb_data     <= '0;
    end else begin
      exmem_regwrite <= idex_ctrl.regwrite;
      exmem_memwrite <= idex_ctrl.memwrite;
      exmem_memtoreg <= idex_ctrl.memtoreg;
      exmem_alu      <= ex_result;
      exmem_wdata    <= ex_b;
      exmem_rd       <= idex_rd;
      memwb_regwrite <= exmem_regwrite;
      memwb_rd       <= exmem_rd;
      memwb_data     <= exmem_memtoreg ? mem_rdata : exmem_alu;
    end
  end
endmodule

// File: tb/tb_riscv_pipeline_top.sv
// Bench for riscv_pipeline_top: per-cycle RF/DM state against an architectural timeline
// model, randomized mid-program resets, and a table of final architectural values.

module tb_riscv_pipeline_top;
  logic clock = 1'b0;
  logic reset = 1'b0;

  riscv_pipeline_top dut (.clock(clock), .reset(reset));

  always #5 clock = ~clock;

  typedef enum {K_LW, K_SW, K_ADD, K_ADDI} kind_t;
  typedef struct {kind_t k; int rd; int rs1; int rs2f; int imm;} insn_t;
  typedef struct {bit is_mem; int idx; logic [31:0] exp;} vec_t;

  insn_t       prog [0:10];
  int          wreg [0:10];
  int          wcyc [0:10];
  logic [31:0] wval [0:10];
  logic [31:0] store_val;
  int          store_addr, store_cyc;
  bit          dm_done;
  vec_t        tab [$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int hold_cnt = 0;

  function automatic logic [31:0] init_word(int addr);
    case (addr)
      0:       return 32'h0000006D;
      40:      return 32'h00FF00FF;
      default: return 32'h0;
    endcase
  endfunction

  // Architectural execution plus the cycle each result becomes visible in RF
  task automatic build_model();
    logic [31:0] ar [0:31];
    int ec;
    for (int r = 0; r < 32; r++) ar[r] = '0;
    ec = 1;
    for (int n = 0; n <= 10; n++) begin
      logic [31:0] v;
      bit stall;
      stall = (n > 0) && prog[n-1].k == K_LW && prog[n-1].rd != 0 &&
              (prog[n-1].rd == prog[n].rs1 || prog[n-1].rd == prog[n].rs2f);
      ec = ec + 1 + (stall ? 1 : 0);
      v = '0;
      wreg[n] = 0;
      case (prog[n].k)
        K_ADD:  v = ar[prog[n].rs1] + ar[prog[n].rs2f];
        K_ADDI: v = ar[prog[n].rs1] + prog[n].imm;
        K_LW:   v = init_word(int'(ar[prog[n].rs1]) + prog[n].imm);
        K_SW: begin
          store_val  = ar[prog[n].rs2f];
          store_addr = int'(ar[prog[n].rs1]) + prog[n].imm;
          store_cyc  = ec + 1;
        end
        default: v = '0;
      endcase
      if (prog[n].k != K_SW) begin
        wreg[n] = prog[n].rd;
        if (prog[n].rd != 0) ar[prog[n].rd] = v;
      end
      wval[n] = v;
      wcyc[n] = ec + 2;
    end
  endtask

  function automatic logic [31:0] exp_reg(int r, int c);
    logic [31:0] v;
    v = '0;
    for (int n = 0; n <= 10; n++)
      if (r != 0 && wreg[n] == r && wcyc[n] <= c) v = wval[n];
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_state(input int c);
    for (int r = 0; r < 32; r++)
      cmp($sformatf("x%0d@cycle%0d", r, c), dut.RF.RF[r], exp_reg(r, c));
    for (int b = 0; b < 4; b++)
      cmp($sformatf("dm[%0d]@cycle%0d", store_addr + b, c), {24'h0, dut.DM.data[store_addr + b]},
          dm_done ? {24'h0, store_val[8*b +: 8]} : 32'h0);
  endtask

  task automatic do_reset(input int ncyc);
    reset = 1'b1;
    #1;
    check_state(-1);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clock);
      #1;
      check_state(-1);
    end
    reset = 1'b0;
    cyc = 0;
    hold_cnt = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (cyc == store_cyc) dm_done = 1'b1;
      if (dut.ifid_pc == 32'h1C) hold_cnt++;
      check_state(cyc);
      cyc++;
    end
  endtask

  task automatic check_table(input string tag);
    foreach (tab[i]) begin
      if (tab[i].is_mem)
        cmp($sformatf("%s dm[%0d]", tag, tab[i].idx), {24'h0, dut.DM.data[tab[i].idx]}, tab[i].exp);
      else
        cmp($sformatf("%s x%0d", tag, tab[i].idx), dut.RF.RF[tab[i].idx], tab[i].exp);
    end
  endtask

  initial begin
    prog[0]  = '{K_LW,   2, 0, 0,  0};
    prog[1]  = '{K_ADDI, 3, 0, 17, 17};
    prog[2]  = '{K_ADDI, 4, 3, 3,  3};
    prog[3]  = '{K_ADDI, 5, 3, 15, 15};
    prog[4]  = '{K_ADD,  6, 3, 5,  0};
    prog[5]  = '{K_ADD,  7, 4, 5,  0};
    prog[6]  = '{K_LW,   8, 0, 8,  40};
    prog[7]  = '{K_ADDI, 9, 8, 0,  256};
    prog[8]  = '{K_ADDI, 0, 0, 0,  0};
    prog[9]  = '{K_SW,   0, 0, 9,  100};
    prog[10] = '{K_ADDI, 10, 0, 18, 50};
    build_model();
    dm_done = 1'b0;

    tab.push_back('{1'b0, 0,  32'h0});
    tab.push_back('{1'b0, 1,  32'h0});
    tab.push_back('{1'b0, 2,  32'h0000006D});
    tab.push_back('{1'b0, 3,  32'h00000011});
    tab.push_back('{1'b0, 4,  32'h00000014});
    tab.push_back('{1'b0, 5,  32'h00000020});
    tab.push_back('{1'b0, 6,  32'h00000031});
    tab.push_back('{1'b0, 7,  32'h00000034});
    tab.push_back('{1'b0, 8,  32'h00FF00FF});
    tab.push_back('{1'b0, 9,  32'h00FF01FF});
    tab.push_back('{1'b0, 10, 32'h00000032});
    tab.push_back('{1'b0, 11, 32'h0});
    tab.push_back('{1'b0, 31, 32'h0});
    tab.push_back('{1'b1, 100, 32'hFF});
    tab.push_back('{1'b1, 101, 32'h01});
    tab.push_back('{1'b1, 102, 32'hFF});
    tab.push_back('{1'b1, 103, 32'h00});
    tab.push_back('{1'b1, 0,   32'h6D});
    tab.push_back('{1'b1, 40,  32'hFF});
    tab.push_back('{1'b1, 41,  32'h00});
    tab.push_back('{1'b1, 42,  32'hFF});

    // Scenario 1: clean run, with the back-to-back addi result checked right when it lands
    do_reset(1);
    run(7);
    cmp("back-to-back x4", dut.RF.RF[4], 32'h00000014);
    run(13);
    check_table("run1");
    cmp("load-use IF/ID hold cycles at 0x1C", hold_cnt, 2);

    // Scenario 2: reset after cycle 8, then a full rerun
    do_reset(1);
    run(8);
    do_reset(1);
    run(20);
    check_table("run2");
    cmp("load-use IF/ID hold cycles rerun", hold_cnt, 2);

    // Randomized reset points and durations
    for (int t = 0; t < 8; t++) begin
      do_reset(int'($urandom_range(1, 3)));
      run(int'($urandom_range(0, 22)));
    end
    do_reset(1);
    run(20);
    check_table("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
